// File: rtl/decoder_nx2n_seq.sv
// Registered N-to-2^N one-hot decoder with direct-load and auto-scan modes.
// Every output comes from a flop; the next-state logic only feeds the register bank.
module decoder_nx2n_seq #(
  parameter int N     = 4,
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              i_valid,
  input  logic [N-1:0]      i,
  output logic [2**N-1:0]   y,
  output logic [N-1:0]      idx,
  output logic              active,
  output logic              wrap
);

  localparam int W = 2**N;
  localparam logic [W-1:0]  ONE        = W'(1);
  localparam logic [N-1:0]  IDX_LAST   = '1;
  localparam logic [15:0]   DWELL_LAST = 16'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t        state, state_n;
  logic [15:0]   dwell, dwell_n;
  logic [W-1:0]  y_n;
  logic [N-1:0]  idx_n;
  logic          wrap_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      y      <= '0;
      idx    <= '0;
      dwell  <= '0;
      active <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      state  <= state_n;
      y      <= y_n;
      idx    <= idx_n;
      dwell  <= dwell_n;
      active <= |y_n;
      wrap   <= wrap_n;
    end
  end

  always_comb begin
    state_n = state;
    y_n     = y;
    idx_n   = idx;
    dwell_n = dwell;
    wrap_n  = 1'b0;
    if (!en) begin
      state_n = IDLE;
      y_n     = '0;
      idx_n   = '0;
      dwell_n = '0;
    end else if (mode) begin
      if (state != SCAN) begin
        // entering scan from anywhere always restarts at output 0
        state_n = SCAN;
        y_n     = ONE;
        idx_n   = '0;
        dwell_n = '0;
      end else if (dwell == DWELL_LAST) begin
        dwell_n = '0;
        idx_n   = idx + N'(1);
        y_n     = ONE << idx_n;
        wrap_n  = (idx == IDX_LAST);
      end else begin
        dwell_n = dwell + 16'd1;
      end
    end else begin
      if (i_valid) begin
        state_n = DIRECT;
        y_n     = ONE << i;
        idx_n   = i;
        dwell_n = '0;
      end else if (state == SCAN) begin
        state_n = IDLE;
        y_n     = '0;
        idx_n   = '0;
        dwell_n = '0;
      end
    end
  end

endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// Scoreboard bench for decoder_nx2n_seq: N=4/DWELL=3 and N=2/DWELL=1 instances.
module tb_decoder_nx2n_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        en4 = 0, mode4 = 0, vld4 = 0;
  logic [3:0]  i4 = '0;
  logic [15:0] y4;
  logic [3:0]  idx4;
  logic        act4, wrap4;

  logic        en2 = 0, mode2 = 0, vld2 = 0;
  logic [1:0]  i2 = '0;
  logic [3:0]  y2;
  logic [1:0]  idx2;
  logic        act2, wrap2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] y;
    logic [3:0]  idx;
    logic        wrap;
    string       nm;
  } exp_t;

  exp_t q4[$];
  exp_t q2[$];

  decoder_nx2n_seq #(.N(4), .DWELL(3)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .mode(mode4), .i_valid(vld4), .i(i4),
    .y(y4), .idx(idx4), .active(act4), .wrap(wrap4)
  );

  decoder_nx2n_seq #(.N(2), .DWELL(1)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .mode(mode2), .i_valid(vld2), .i(i2),
    .y(y2), .idx(idx2), .active(act2), .wrap(wrap2)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: outputs settle after the rising edge, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    cmp("onehot4", {31'd0, $onehot0(y4) && (act4 == (y4 != 16'd0))}, 32'd1);
    cmp("onehot2", {31'd0, $onehot0(y2) && (act2 == (y2 != 4'd0))}, 32'd1);
    if (q4.size() > 0) begin
      e = q4.pop_front();
      cmp({e.nm, ".y"},      {16'd0, y4},    {16'd0, e.y});
      cmp({e.nm, ".idx"},    {28'd0, idx4},  {28'd0, e.idx});
      cmp({e.nm, ".active"}, {31'd0, act4},  {31'd0, e.y != 16'd0});
      cmp({e.nm, ".wrap"},   {31'd0, wrap4}, {31'd0, e.wrap});
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      cmp({e.nm, ".y"},      {28'd0, y2},    {16'd0, e.y});
      cmp({e.nm, ".idx"},    {30'd0, idx2},  {28'd0, e.idx});
      cmp({e.nm, ".active"}, {31'd0, act2},  {31'd0, e.y != 16'd0});
      cmp({e.nm, ".wrap"},   {31'd0, wrap2}, {31'd0, e.wrap});
    end
  end

  // Drive one cycle of inputs and queue what the outputs must be after the next edge.
  task automatic step4(input logic e, input logic m, input logic v, input logic [3:0] sel,
                       input logic [15:0] ey, input logic [3:0] eidx, input logic ew,
                       input string nm);
    @(negedge clk); #1;
    en4 = e; mode4 = m; vld4 = v; i4 = sel;
    q4.push_back('{y: ey, idx: eidx, wrap: ew, nm: nm});
  endtask

  task automatic step2(input logic e, input logic m,
                       input logic [3:0] ey, input logic [1:0] eidx, input logic ew,
                       input string nm);
    @(negedge clk); #1;
    en2 = e; mode2 = m;
    q2.push_back('{y: {12'd0, ey}, idx: {2'd0, eidx}, wrap: ew, nm: nm});
  endtask

  // Scan from a fresh entry: cycle k shows output k/3, wrap on each return to 0 after the first.
  task automatic scan4(input int n, input string nm);
    for (int k = 0; k < n; k++) begin
      int s;
      s = (k / 3) % 16;
      step4(1'b1, 1'b1, k[0], k[3:0], 16'd1 << s, s[3:0],
            (k > 0) && (k % 3 == 0) && (s == 0), nm);
    end
  endtask

  initial begin
    #3;
    cmp("rst0.y",    {16'd0, y4}, 32'd0);
    cmp("rst0.idx",  {28'd0, idx4}, 32'd0);
    cmp("rst0.act",  {31'd0, act4}, 32'd0);
    cmp("rst0.wrap", {31'd0, wrap4}, 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;

    // scan briefly, then reset mid-cycle: outputs must clear before any edge
    scan4(7, "pre_rst_scan");
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    cmp("async_rst.y",    {16'd0, y4}, 32'd0);
    cmp("async_rst.idx",  {28'd0, idx4}, 32'd0);
    cmp("async_rst.act",  {31'd0, act4}, 32'd0);
    cmp("async_rst.wrap", {31'd0, wrap4}, 32'd0);
    en4 = 1'b0; mode4 = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) step4(1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 4'd0, 1'b0, "post_rst_en0");

    // idle with mode=0 and no strobe stays idle
    step4(1'b1, 1'b0, 1'b0, 4'd3, 16'd0, 4'd0, 1'b0, "idle_hold");

    // direct sweep: load each code, then hold for 9 cycles with a changing i
    for (int s = 0; s < 16; s++) begin
      step4(1'b1, 1'b0, 1'b1, s[3:0], 16'd1 << s, s[3:0], 1'b0, "direct_load");
      for (int h = 0; h < 9; h++)
        step4(1'b1, 1'b0, 1'b0, 4'(s + h + 1), 16'd1 << s, s[3:0], 1'b0, "direct_hold");
    end
    step4(1'b1, 1'b0, 1'b1, 4'd15, 16'h8000, 4'd15, 1'b0, "direct_reload");

    // direct -> scan restarts at 0; run a full wrap and on to idx 5
    scan4(64, "scan_wrap");

    // scan -> direct with a load on the same edge
    step4(1'b1, 1'b0, 1'b1, 4'd9, 16'h0200, 4'd9, 1'b0, "scan_to_direct");
    step4(1'b1, 1'b0, 1'b0, 4'd2, 16'h0200, 4'd9, 1'b0, "direct_after_scan");

    // back to scan up to idx 7, then drop en for 2 cycles
    scan4(22, "rescan");
    step4(1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 4'd0, 1'b0, "en_drop");
    step4(1'b0, 1'b1, 1'b1, 4'd4, 16'd0, 4'd0, 1'b0, "en_drop");
    scan4(8, "en_restart");

    // scan -> mode 0 without a strobe goes idle
    step4(1'b1, 1'b0, 1'b0, 4'd6, 16'd0, 4'd0, 1'b0, "scan_to_idle");
    step4(1'b1, 1'b0, 1'b0, 4'd6, 16'd0, 4'd0, 1'b0, "idle_stay");

    // N=2, DWELL=1: advance every cycle
    for (int k = 0; k < 10; k++)
      step2(1'b1, 1'b1, 4'd1 << (k % 4), 2'(k % 4), (k > 0) && (k % 4 == 0), "n2_scan");
    step2(1'b0, 1'b1, 4'd0, 2'd0, 1'b0, "n2_en0");

    repeat (2) @(negedge clk);
    #1;
    cmp("queues_drained", q4.size() + q2.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_nx2n_seq.md
Name: decoder_nx2n_seq

Overview:
Parametrised, registered N-to-2^N one-hot decoder, the successor to the fixed 4x16 combinational decoder. It has two modes. Direct mode latches a select on a valid strobe. Scan mode auto-walks the outputs with a programmable dwell time, for row/column scanning and chip-select sequencing. All outputs are registered, so it drops into synchronous datapaths without a combinational select path.

Parameters:
N, 4, select width; output width is 2^N.
DWELL, 4, clock cycles each output stays active in scan mode; legal range 1..65535.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  block enable; 0 forces outputs idle.
mode  input  1  0 = direct, 1 = scan.
i_valid  input  1  direct-mode load strobe.
i  input  N  direct-mode select value.
y  output  2^N  registered one-hot output (all-zero when idle).
idx  output  N  index of the currently asserted y bit (0 when idle).
active  output  1  high when y is non-zero.
wrap  output  1  one-cycle pulse when scan index wraps from 2^N-1 to 0.

Behaviour:
- Reset (async, rst=1): y=0, idx=0, active=0, wrap=0, dwell counter=0, state=IDLE. These values hold while rst is high. The first update is on the first rising edge after deassertion.
- States: IDLE, DIRECT, SCAN. All transitions are evaluated on the rising clk edge.
- IDLE:
  - y=0.
  - en=1 & mode=1: go to SCAN. Same edge: y=1, idx=0, dwell=0.
  - en=1 & mode=0 & i_valid=1: go to DIRECT. Same edge: y=1<<i, idx=i.
  - en=1 & mode=0 & i_valid=0: stay in IDLE.
- DIRECT:
  - Each edge with i_valid=1: y<=1<<i, idx<=i. Latency is 1 cycle from the valid edge to y.
  - i_valid=0: y and idx hold.
  - The same i re-loaded is legal; y is unchanged.
- SCAN:
  - Dwell counter increments each edge.
  - When dwell=DWELL-1: dwell<=0 and idx<=idx+1 (mod 2^N), y<=1<<(idx+1).
  - When idx advances from 2^N-1 to 0: wrap=1 for exactly that cycle (coincident with y=1). Otherwise wrap=0.
  - i_valid and i are ignored.
  - DWELL=1: idx advances every cycle.
- Mode change while en=1:
  - SCAN to DIRECT: next edge y=0, idx=0, state=IDLE. If i_valid=1 on that same edge, the load takes priority: state=DIRECT, y=1<<i.
  - DIRECT to SCAN: next edge state=SCAN, y=1, idx=0, dwell=0 (scan always restarts at 0).
- en=0 (any state): next edge y=0, idx=0, dwell=0, wrap=0, state=IDLE. en=0 overrides mode and i_valid.
- active is a registered copy of (y!=0), updated on the same edge as y. It is never one cycle late.
- Reset mid-scan: outputs clear immediately (asynchronously). After release, behaviour is identical to power-up.
- Invariant: y has at most one bit set, and y==0 exactly when active==0.

Test Plan:
- Reset/idle (N=4, DWELL=3): assert rst mid-cycle with SCAN running -> y=0, idx=0, active=0 immediately, before the next edge. Release with en=0 for 5 cycles -> y stays 0.
- Direct sweep: mode=0, en=1, apply i=0..15 each with a 1-cycle i_valid pulse and 10-cycle spacing -> one cycle after each pulse y=16'h0001<<i, idx=i, active=1. y holds between pulses. Check all 16 codes.
- Scan dwell/wrap: mode=1, en=1, DWELL=3 -> y=0x0001 for 3 cycles, then 0x0002, and so on up to 0x8000. Next step y=0x0001 with wrap=1 for one cycle; the wrap period is 48 cycles. i_valid toggling has no effect.
- Mode switching: scan until idx=5, then set mode=0 with i_valid=1, i=9 on the same edge -> next edge y=0x0200, idx=9. Set mode=1 -> next edge y=0x0001, idx=0, dwell restarted (0x0001 lasts 3 cycles).
- Enable gating: during scan at idx=7 drop en for 2 cycles -> y=0 and wrap=0 on the next edge. Re-raise en with mode=1 -> scan restarts at idx=0.
- Corner parameters: N=2, DWELL=1 -> y cycles 0001, 0010, 0100, 1000 every cycle, with wrap on each 0001 after the first. Check the one-hot invariant every cycle across all scenarios.
